// File: rtl/data_io_fifo.sv
// SPI file-download receiver: oversamples the IO-controller SPI lines, decodes FILE_TX/FILE_TX_DAT/FILE_INDEX
// and buffers packed {address, data} words in a small FIFO. Optional running checksum: DATA_IO_CHECKSUM_EN.
module data_io_fifo #(
   parameter int unsigned START_ADDR = 0,
   parameter int unsigned AW         = 24,
   parameter int unsigned DW         = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          sck,
   input  logic          ss,
   input  logic          sdi,
   output logic          downloading,
   output logic [7:0]    index,
   output logic [AW-1:0] size,
   output logic          overflow,
   output logic          wr,
   input  logic          wr_ack,
   output logic [AW-1:0] a,
   output logic [DW-1:0] d
`ifdef DATA_IO_CHECKSUM_EN
   ,
   output logic [15:0]   checksum
`endif
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   localparam logic [7:0] CMD_FILE_TX     = 8'h53;
   localparam logic [7:0] CMD_FILE_TX_DAT = 8'h54;
   localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;

   logic          sck_meta_q, sck_sync_q, sck_prev_q;
   logic          ss_meta_q, ss_sync_q;
   logic          sdi_meta_q, sdi_sync_q;

   logic [3:0]    cnt_q, cnt_d;
   logic [6:0]    sr_q, sr_d;
   logic [7:0]    cmd_q, cmd_d;
   logic          dl_q, dl_d;
   logic          end_q, end_d;
   logic [7:0]    index_q, index_d;
   logic [AW-1:0] size_q, size_d;
   logic          ovf_q, ovf_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          half_q, half_d;
   logic [7:0]    lo_q, lo_d;
`ifdef DATA_IO_CHECKSUM_EN
   logic [15:0]   csum_q, csum_d;
`endif

   logic [AW-1:0] mem_a_q [FIFO_DEPTH];
   logic [DW-1:0] mem_d_q [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] fcnt_q;

   logic          sck_rise;
   logic [7:0]    byte_w;
   logic          dat_done;
   logic          fifo_full, fifo_empty;
   logic          push_req, push_ok, pop;
   logic [DW-1:0] push_data;

   assign sck_rise   = sck_sync_q & ~sck_prev_q;
   assign byte_w     = {sr_q, sdi_sync_q};
   assign dat_done   = sck_rise && !ss_sync_q && (cnt_q == 4'd15);
   assign fifo_full  = (fcnt_q == CW'(FIFO_DEPTH));
   assign fifo_empty = (fcnt_q == '0);
   assign push_ok    = push_req && !fifo_full;

   // Handshake: wr is high whenever the FIFO holds an entry and a/d show that head entry;
   // the head is consumed in the clk where wr and wr_ack are both high; wr_ack alone does nothing.
   assign pop = !fifo_empty && wr_ack;
   assign wr  = !fifo_empty;
   assign a   = fifo_empty ? '0 : mem_a_q[rd_ptr_q];
   assign d   = fifo_empty ? '0 : mem_d_q[rd_ptr_q];

   assign downloading = dl_q;
   assign index       = index_q;
   assign size        = size_q;
   assign overflow    = ovf_q;
`ifdef DATA_IO_CHECKSUM_EN
   assign checksum    = csum_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_meta_q <= 1'b0;
         sck_sync_q <= 1'b0;
         sck_prev_q <= 1'b0;
         ss_meta_q  <= 1'b1;
         ss_sync_q  <= 1'b1;
         sdi_meta_q <= 1'b0;
         sdi_sync_q <= 1'b0;
      end else begin
         sck_meta_q <= sck;
         sck_sync_q <= sck_meta_q;
         sck_prev_q <= sck_sync_q;
         ss_meta_q  <= ss;
         ss_sync_q  <= ss_meta_q;
         sdi_meta_q <= sdi;
         sdi_sync_q <= sdi_meta_q;
      end
   end

   always_comb begin
      cnt_d     = cnt_q;
      sr_d      = sr_q;
      cmd_d     = cmd_q;
      dl_d      = dl_q;
      end_d     = end_q;
      index_d   = index_q;
      size_d    = size_q;
      ovf_d     = ovf_q;
      addr_d    = addr_q;
      half_d    = half_q;
      lo_d      = lo_q;
`ifdef DATA_IO_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      push_req  = 1'b0;
      push_data = '0;

      if (ss_sync_q) begin
         cnt_d = 4'd0;
      end else if (sck_rise) begin
         sr_d  = byte_w[6:0];
         // Bytes after the command byte cycle through counts 8..15.
         cnt_d = (cnt_q == 4'd15) ? 4'd8 : cnt_q + 4'd1;
         if (cnt_q == 4'd7) cmd_d = byte_w;
      end

      if (dat_done) begin
         case (cmd_q)
            CMD_FILE_TX: begin
               if (byte_w[0]) begin
                  dl_d   = 1'b1;
                  end_d  = 1'b0;
                  size_d = '0;
                  addr_d = AW'(START_ADDR);
                  ovf_d  = 1'b0;
                  half_d = 1'b0;
`ifdef DATA_IO_CHECKSUM_EN
                  csum_d = '0;
`endif
               end else begin
                  end_d = 1'b1;
                  if (DW == 16 && half_q) begin
                     push_req  = 1'b1;
                     push_data = DW'({8'h00, lo_q});
                     half_d    = 1'b0;
                  end
               end
            end
            CMD_FILE_TX_DAT: begin
               size_d = size_q + AW'(1);
`ifdef DATA_IO_CHECKSUM_EN
               csum_d = csum_q + {8'h00, byte_w};
`endif
               if (DW == 8) begin
                  push_req  = 1'b1;
                  push_data = DW'(byte_w);
               end else if (half_q) begin
                  push_req  = 1'b1;
                  push_data = DW'({byte_w, lo_q});
                  half_d    = 1'b0;
               end else begin
                  lo_d   = byte_w;
                  half_d = 1'b1;
               end
            end
            CMD_FILE_INDEX: index_d = byte_w;
            default: ;
         endcase
      end

      // Dropped words still consume an address so later words land where expected.
      if (push_req) begin
         addr_d = addr_q + AW'(1);
         if (fifo_full) ovf_d = 1'b1;
      end

      if (end_q && end_d && fifo_empty && !push_req) begin
         dl_d  = 1'b0;
         end_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= 4'd0;
         sr_q    <= '0;
         cmd_q   <= '0;
         dl_q    <= 1'b0;
         end_q   <= 1'b0;
         index_q <= '0;
         size_q  <= '0;
         ovf_q   <= 1'b0;
         addr_q  <= AW'(START_ADDR);
         half_q  <= 1'b0;
         lo_q    <= '0;
`ifdef DATA_IO_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         cmd_q   <= cmd_d;
         dl_q    <= dl_d;
         end_q   <= end_d;
         index_q <= index_d;
         size_q  <= size_d;
         ovf_q   <= ovf_d;
         addr_q  <= addr_d;
         half_q  <= half_d;
         lo_q    <= lo_d;
`ifdef DATA_IO_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         fcnt_q   <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push_ok, pop})
            2'b10:   fcnt_q <= fcnt_q + CW'(1);
            2'b01:   fcnt_q <= fcnt_q - CW'(1);
            default: fcnt_q <= fcnt_q;
         endcase
      end
   end

   // Storage needs no reset: a/d are forced to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_ok && !reset) begin
         mem_a_q[wr_ptr_q] <= addr_q;
         mem_d_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: tb/tb_data_io_fifo.sv
// Directed bench for data_io_fifo: a DW=8 and a DW=16 instance decode the same SPI stream.
module tb_data_io_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, sck, ss, sdi, wr_ack8, wr_ack16;
   logic        dl8, ovf8, wr8, dl16, ovf16, wr16;
   logic [7:0]  idx8, idx16, d8;
   logic [23:0] size8, size16, a8, a16;
   logic [15:0] d16;
`ifdef DATA_IO_CHECKSUM_EN
   logic [15:0] cs8, cs16;
`endif

   int checks = 0;
   int errors = 0;
   logic [47:0] log8_q[$], log16_q[$], exp8_q[$], exp16_q[$];

   data_io_fifo #(.START_ADDR(32'h100), .AW(24), .DW(8), .FIFO_DEPTH(4)) u8 (
      .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
      .downloading(dl8), .index(idx8), .size(size8), .overflow(ovf8),
      .wr(wr8), .wr_ack(wr_ack8), .a(a8), .d(d8)
`ifdef DATA_IO_CHECKSUM_EN
      , .checksum(cs8)
`endif
   );

   data_io_fifo #(.START_ADDR(0), .AW(24), .DW(16), .FIFO_DEPTH(4)) u16 (
      .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
      .downloading(dl16), .index(idx16), .size(size16), .overflow(ovf16),
      .wr(wr16), .wr_ack(wr_ack16), .a(a16), .d(d16)
`ifdef DATA_IO_CHECKSUM_EN
      , .checksum(cs16)
`endif
   );

   // Inputs only change on negedges, so the popped head is stable here.
   always @(posedge clk) begin
      if (!reset && wr8 && wr_ack8)   log8_q.push_back({16'h0, a8, d8});
      if (!reset && wr16 && wr_ack16) log16_q.push_back({8'h0, a16, d16});
   end

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic spi_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         sdi = b[i];
         #40 sck = 1'b1;
         #40 sck = 1'b0;
      end
   endtask

   // One select frame: command byte then n data bytes, byte k taken from bits [8k+7:8k].
   task automatic send(input logic [7:0] cmd, input logic [63:0] data, input int n);
      ss = 1'b0;
      #40;
      spi_byte(cmd);
      for (int k = 0; k < n; k++) spi_byte(data[8*k +: 8]);
      #40 ss = 1'b1;
      #80;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && (dl8 || dl16); i++) @(negedge clk);
      check("dl8_idle", dl8, 1'b0);
      check("dl16_idle", dl16, 1'b0);
   endtask

   task automatic cmp_logs(input string tag);
      check({tag, "_n8"}, log8_q.size(), exp8_q.size());
      for (int i = 0; i < log8_q.size() && i < exp8_q.size(); i++)
         check({tag, "_e8"}, log8_q[i], exp8_q[i]);
      check({tag, "_n16"}, log16_q.size(), exp16_q.size());
      for (int i = 0; i < log16_q.size() && i < exp16_q.size(); i++)
         check({tag, "_e16"}, log16_q[i], exp16_q[i]);
      log8_q.delete(); log16_q.delete(); exp8_q.delete(); exp16_q.delete();
   endtask

   initial begin
      reset = 1'b1; sck = 1'b0; ss = 1'b1; sdi = 1'b0; wr_ack8 = 1'b0; wr_ack16 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_dl", dl8, 1'b0);
      check("rst_wr", wr8, 1'b0);
      check("rst_size", size8, 24'h0);
      check("rst_a", a8, 24'h0);
      check("rst_d16", d16, 16'h0);

      // Basic download, consumer always ready
      wr_ack8 = 1'b1; wr_ack16 = 1'b1;
      send(8'h53, 64'h01, 1);
      check("start_dl8", dl8, 1'b1);
      check("start_dl16", dl16, 1'b1);
      send(8'h54, 64'h332211, 3);
      check("size8_3", size8, 24'd3);
      check("size16_3", size16, 24'd3);
      send(8'h53, 64'h00, 1);
      wait_idle();
      exp8_q.push_back({16'h0, 24'h100, 8'h11});
      exp8_q.push_back({16'h0, 24'h101, 8'h22});
      exp8_q.push_back({16'h0, 24'h102, 8'h33});
      exp16_q.push_back({8'h0, 24'h0, 16'h2211});
      exp16_q.push_back({8'h0, 24'h1, 16'h0033});
      cmp_logs("dl_a");

      // Little-endian packing with odd-byte flush
      send(8'h53, 64'h01, 1);
      send(8'h54, 64'hCCBBAA, 3);
      send(8'h53, 64'h00, 1);
      wait_idle();
      check("size16_abc", size16, 24'd3);
      exp8_q.push_back({16'h0, 24'h100, 8'hAA});
      exp8_q.push_back({16'h0, 24'h101, 8'hBB});
      exp8_q.push_back({16'h0, 24'h102, 8'hCC});
      exp16_q.push_back({8'h0, 24'h0, 16'hBBAA});
      exp16_q.push_back({8'h0, 24'h1, 16'h00CC});
      cmp_logs("dl_b");

      // Overflow with consumer stalled
      wr_ack8 = 1'b0; wr_ack16 = 1'b0;
      send(8'h53, 64'h01, 1);
      send(8'h54, 64'h060504030201, 6);
      check("ovf8", ovf8, 1'b1);
      check("ovf16", ovf16, 1'b0);
      check("ovf_wr8", wr8, 1'b1);
      check("ovf_size8", size8, 24'd6);
      check("ovf_head_a8", a8, 24'h100);
      check("ovf_head_d8", d8, 8'h01);
      send(8'h53, 64'h00, 1);
      check("ovf_dl8_held", dl8, 1'b1);
      wr_ack8 = 1'b1; wr_ack16 = 1'b1;
      wait_idle();
      for (int i = 0; i < 4; i++) exp8_q.push_back({16'h0, 24'h100 + 24'(i), 8'(i + 1)});
      exp16_q.push_back({8'h0, 24'h0, 16'h0201});
      exp16_q.push_back({8'h0, 24'h1, 16'h0403});
      exp16_q.push_back({8'h0, 24'h2, 16'h0605});
      cmp_logs("ovf");

      // File index command
      send(8'h55, 64'h07, 1);
      check("idx8", idx8, 8'h07);
      check("idx16", idx16, 8'h07);
      check("idx_size8", size8, 24'd6);
      check("idx_wr8", wr8, 1'b0);
      cmp_logs("idx");

      // Reset in the middle of a transfer
      wr_ack8 = 1'b0; wr_ack16 = 1'b0;
      send(8'h53, 64'h01, 1);
      ss = 1'b0;
      #40;
      spi_byte(8'h54);
      spi_byte(8'h11);
      spi_byte(8'h22);
      #40;
      check("pre_rst_size8", size8, 24'd2);
      check("pre_rst_wr8", wr8, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_dl8", dl8, 1'b0);
      check("mid_rst_wr8", wr8, 1'b0);
      check("mid_rst_a8", a8, 24'h0);
      check("mid_rst_d8", d8, 8'h0);
      check("mid_rst_size8", size8, 24'h0);
      check("mid_rst_idx8", idx8, 8'h0);
      check("mid_rst_ovf8", ovf8, 1'b0);
      check("mid_rst_wr16", wr16, 1'b0);
      reset = 1'b0;
      ss = 1'b1;
      #80;
      wr_ack8 = 1'b1; wr_ack16 = 1'b1;
      send(8'h53, 64'h01, 1);
      send(8'h54, 64'h5A, 1);
      send(8'h53, 64'h00, 1);
      wait_idle();
      check("post_rst_size8", size8, 24'd1);
      exp8_q.push_back({16'h0, 24'h100, 8'h5A});
      exp16_q.push_back({8'h0, 24'h0, 16'h005A});
      cmp_logs("post_rst");

`ifdef DATA_IO_CHECKSUM_EN
      send(8'h53, 64'h01, 1);
      send(8'h54, 64'h02FFFF, 3);
      check("csum8", cs8, 16'h0200);
      check("csum16", cs16, 16'h0200);
      send(8'h53, 64'h00, 1);
      wait_idle();
      log8_q.delete(); log16_q.delete();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
